// File: rtl/spi_slave_16_pkg.sv
// Shared constants for the 16-bit SPI slave.
package spi_slave_16_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

endpackage

// File: rtl/spi_slave_16_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input with registered
// rise/fall pulses, one clock after the synchronized level changes.
module spi_slave_16_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & dly_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_16.sv
// Mode-0 SPI slave, 16-bit words, oversampled by clk_100.
// Received words are strobed to the parent; txd_data is shifted back out.
module spi_slave_16
    import spi_slave_16_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_100,
    input  logic              RSTn,
    input  logic              SCK,
    input  logic              SPISIMO,
    output logic              SPISOMI,
    input  logic              SPISTE,
    output logic              rxd_flag,
    output logic [DATA_W-1:0] rxd_data,
    input  logic [DATA_W-1:0] txd_data
);

    logic sck_rise, sck_fall;
    logic ste_rise, ste_fall;

    logic [SYNC_STAGES-1:0] simo_sync_q;
    logic                   simo_s;

    logic [DATA_W-1:0] rx_q,  rx_d;
    logic [DATA_W-1:0] tx_q,  tx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rxd_q, rxd_d;
    logic              flag_q, flag_d;
    logic              act_q, act_d;

    spi_slave_16_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk_i   (clk_100),
        .rst_i   (RSTn),
        .async_i (SCK),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    spi_slave_16_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ste_sync (
        .clk_i   (clk_100),
        .rst_i   (RSTn),
        .async_i (SPISTE),
        .rise_o  (ste_rise),
        .fall_o  (ste_fall)
    );

    assign simo_s = simo_sync_q[SYNC_STAGES-1];

    always_comb begin
        rx_d   = rx_q;
        tx_d   = tx_q;
        cnt_d  = cnt_q;
        rxd_d  = rxd_q;
        flag_d = 1'b0;
        act_d  = act_q;

        if (ste_fall) begin
            act_d = 1'b1;
            tx_d  = txd_data;
        end
        if (ste_rise) begin
            act_d = 1'b0;
        end

        if (!act_q) begin
            cnt_d = '0;
        end else if (sck_rise) begin
            rx_d  = {rx_q[DATA_W-2:0], simo_s};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                rxd_d  = rx_d;
                flag_d = 1'b1;
                tx_d   = txd_data;
            end
        end else if (sck_fall) begin
            // First falling edge of a back-to-back word: reload instead of
            // shifting so a parent reply written just after the strobe is sent.
            if (cnt_q == '0) begin
                tx_d = txd_data;
            end else begin
                tx_d = {tx_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_100) begin
        if (RSTn) begin
            simo_sync_q <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            cnt_q       <= '0;
            rxd_q       <= '0;
            flag_q      <= 1'b0;
            act_q       <= 1'b0;
        end else begin
            simo_sync_q <= {simo_sync_q[SYNC_STAGES-2:0], SPISIMO};
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            cnt_q       <= cnt_d;
            rxd_q       <= rxd_d;
            flag_q      <= flag_d;
            act_q       <= act_d;
        end
    end

    assign SPISOMI  = act_q & tx_q[DATA_W-1];
    assign rxd_flag = flag_q;
    assign rxd_data = rxd_q;

endmodule

// File: tb/tb_spi_slave_16.sv
// Directed bench for spi_slave_16: frames, back-to-back words, abort, reset.
module tb_spi_slave_16;

    logic        clk_100 = 1'b0;
    logic        RSTn;
    logic        SCK;
    logic        SPISIMO;
    logic        SPISOMI;
    logic        SPISTE;
    logic        rxd_flag;
    logic [15:0] rxd_data;
    logic [15:0] txd_data;

    int checks = 0;
    int errors = 0;
    int nstrobe = 0;
    logic [15:0] miso_a, miso_b;

    spi_slave_16 dut (
        .clk_100  (clk_100),
        .RSTn     (RSTn),
        .SCK      (SCK),
        .SPISIMO  (SPISIMO),
        .SPISOMI  (SPISOMI),
        .SPISTE   (SPISTE),
        .rxd_flag (rxd_flag),
        .rxd_data (rxd_data),
        .txd_data (txd_data)
    );

    always #5 clk_100 = ~clk_100;

    always @(negedge clk_100) begin
        if (rxd_flag) nstrobe = nstrobe + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Master side: 50 ns low / 50 ns high per bit (10 MHz). Checks the strobe
    // timing around the last rising edge of the transfer.
    task automatic spi_frame(input logic [15:0] mosi, input int nbits,
                             input logic exp_flag, input logic [15:0] exp_rxd,
                             input logic set_txd, input logic [15:0] new_txd,
                             output logic [15:0] miso);
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            SPISIMO = mosi[15-i];
            #50;
            miso[15-i] = SPISOMI;
            SCK = 1'b1;
            if (i == nbits - 1) begin
                #30;
                check("flag_early", {31'b0, rxd_flag}, 32'd0);
                #10;
                check("flag_at_latency", {31'b0, rxd_flag}, {31'b0, exp_flag});
                if (exp_flag) check("rxd_at_strobe", {16'b0, rxd_data}, {16'b0, exp_rxd});
                if (set_txd) txd_data = new_txd;
                #10;
                check("flag_one_cycle", {31'b0, rxd_flag}, 32'd0);
            end else begin
                #50;
            end
            SCK = 1'b0;
        end
    endtask

    initial begin
        RSTn = 1'b1; SCK = 1'b0; SPISIMO = 1'b0; SPISTE = 1'b1; txd_data = 16'h0000;
        #50;
        check("reset_rxd", {16'b0, rxd_data}, 32'h0);
        check("reset_flag", {31'b0, rxd_flag}, 32'd0);
        check("reset_somi", {31'b0, SPISOMI}, 32'd0);
        RSTn = 1'b0;
        #100;

        // single frame
        txd_data = 16'hA5C3;
        SPISTE = 1'b0;
        #100;
        spi_frame(16'h4123, 16, 1'b1, 16'h4123, 1'b0, 16'h0, miso_a);
        check("frame1_miso", {16'b0, miso_a}, 32'h0000A5C3);
        #100 SPISTE = 1'b1;
        #100;
        check("frame1_strobes", nstrobe, 32'd1);
        check("frame1_hold", {16'b0, rxd_data}, 32'h00004123);
        check("idle_somi", {31'b0, SPISOMI}, 32'd0);

        // back-to-back words, parent answers right after the first strobe
        txd_data = 16'h5A5A;
        SPISTE = 1'b0;
        #100;
        spi_frame(16'h8001, 16, 1'b1, 16'h8001, 1'b1, 16'h1234, miso_a);
        spi_frame(16'h7FFE, 16, 1'b1, 16'h7FFE, 1'b0, 16'h0, miso_b);
        check("b2b_miso1", {16'b0, miso_a}, 32'h00005A5A);
        check("b2b_miso2", {16'b0, miso_b}, 32'h00001234);
        #100 SPISTE = 1'b1;
        #100;
        check("b2b_strobes", nstrobe, 32'd3);
        check("b2b_rxd", {16'b0, rxd_data}, 32'h00007FFE);

        // aborted frame after 9 bits, then a full word
        txd_data = 16'h0000;
        SPISTE = 1'b0;
        #100;
        spi_frame(16'hAAAA, 9, 1'b0, 16'h0, 1'b0, 16'h0, miso_a);
        #50 SPISTE = 1'b1;
        #100;
        check("abort_strobes", nstrobe, 32'd3);
        check("abort_rxd", {16'b0, rxd_data}, 32'h00007FFE);
        SPISTE = 1'b0;
        #100;
        spi_frame(16'hFFFF, 16, 1'b1, 16'hFFFF, 1'b0, 16'h0, miso_a);
        #100 SPISTE = 1'b1;
        #100;
        check("after_abort_strobes", nstrobe, 32'd4);
        check("after_abort_rxd", {16'b0, rxd_data}, 32'h0000FFFF);

        // SCK toggling while deselected
        for (int i = 0; i < 16; i++) begin
            SPISIMO = 1'($urandom_range(0, 1));
            #50 SCK = 1'b1;
            #40;
            check("desel_somi", {31'b0, SPISOMI}, 32'd0);
            #10 SCK = 1'b0;
        end
        #100;
        check("desel_strobes", nstrobe, 32'd4);
        check("desel_rxd", {16'b0, rxd_data}, 32'h0000FFFF);

        // reset in the middle of a frame
        txd_data = 16'h3C3C;
        SPISTE = 1'b0;
        #100;
        spi_frame(16'h5555, 8, 1'b0, 16'h0, 1'b0, 16'h0, miso_a);
        RSTn = 1'b1;
        #30;
        check("midrst_rxd", {16'b0, rxd_data}, 32'h0);
        check("midrst_somi", {31'b0, SPISOMI}, 32'd0);
        SPISTE = 1'b1;
        #20 RSTn = 1'b0;
        #100;
        SPISTE = 1'b0;
        #100;
        spi_frame(16'h0F0F, 16, 1'b1, 16'h0F0F, 1'b0, 16'h0, miso_a);
        check("midrst_miso", {16'b0, miso_a}, 32'h00003C3C);
        #100 SPISTE = 1'b1;
        #100;
        check("midrst_strobes", nstrobe, 32'd5);
        check("midrst_final_rxd", {16'b0, rxd_data}, 32'h00000F0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
